pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the datapath payload (PC, bus values, immediates).
REQ-002 Parameter CTRL_W, default 40: width of the packed control-signal field.
REQ-003 Parameter CLEAR_DATA, default 1: 1 = flush zeroes payload registers; 0 = payload retained, only control and valid cleared.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  upstream stage presents a valid instruction.
REQ-007 Port in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
REQ-008 Port in_data  input  DATA_W  upstream payload.
REQ-009 Port in_ctrl  input  CTRL_W  upstream control bits.
REQ-010 Port flush  input  1  squash all held and incoming instructions (hazard/branch/exception bubble).
REQ-011 Port out_valid  output  1  main entry holds a valid instruction.
REQ-012 Port out_ready  input  1  downstream stage accepts this cycle.
REQ-013 Port out_data  output  DATA_W  main-entry payload.
REQ-014 Port out_ctrl  output  CTRL_W  main-entry control; forced to all-zero whenever out_valid=0.
REQ-015 Port occupancy  output  2  entries held: 0, 1 or 2.
REQ-016 Port flush_cnt  output  16  count of flushes that discarded at least one valid entry.

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; each holds data, ctrl, valid.
REQ-018 Accept = in_valid & in_ready; Release = out_valid & out_ready.
REQ-019 State SHALL be EMPTY, ONE, or TWO, encoded as occupancy 0, 1, 2.
REQ-020 EMPTY: Accept -> ONE, entry loaded into main; else stay.
REQ-021 ONE: Accept & Release -> ONE, main reloaded with input; Accept & !Release -> TWO, input to skid; !Accept & Release -> EMPTY; neither -> hold.
REQ-022 TWO: in_ready=0; Release -> ONE, skid moves to main same edge, skid cleared; else hold.
REQ-023 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; the stall signal is in_ready=0.
REQ-024 Latency SHALL be exactly 1 cycle from Accept to out_valid when the stage is EMPTY or releasing.
REQ-025 Order SHALL be strictly FIFO; no entry dropped or duplicated absent flush.
REQ-026 flush SHALL have priority over all other events: next edge -> EMPTY, both valids 0, both ctrl 0, payload 0 if CLEAR_DATA=1.
REQ-027 An Accept in the same cycle as flush is discarded; upstream sees the handshake complete.
REQ-028 A Release in the same cycle as flush completes normally downstream; that entry is not counted as discarded.
REQ-029 flush_cnt SHALL increment by 1 when flush=1 and any entry is discarded: held entries other than the released main, or the incoming Accept.
REQ-030 flush_cnt SHALL saturate at 16'hFFFF.
REQ-031 flush with nothing to discard is legal; state and counter are unchanged.
REQ-032 Payload and ctrl SHALL pass unmodified, bit-exact, through either entry.

Reset
REQ-033 rst_n=0 SHALL immediately, independent of clk, force: occupancy=0, out_valid=0, out_ctrl=0, out_data=0, skid cleared, flush_cnt=0.
REQ-034 in_ready SHALL be 1 while rst_n=0 and after release.
REQ-035 Reset asserted mid-operation discards all held entries without incrementing flush_cnt.
REQ-036 First Accept is honoured on the first rising edge after rst_n deasserts.

Verification
REQ-037 Streaming: out_ready=1, in_valid=1, data 1,2,3… each cycle -> out_data 1,2,3… one cycle later; occupancy stays 1; in_ready stays 1.
REQ-038 Backpressure: out_ready=0 after D=0xA, accept D=0xB -> occupancy=2, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB on successive cycles.
REQ-039 Flush full: occupancy=2, flush=1, out_ready=0 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, flush_cnt=1; with CLEAR_DATA=1, out_data=0.
REQ-040 Flush with simultaneous Release and Accept at occupancy=1 -> downstream receives main; incoming dropped; flush_cnt +1; occupancy=0.
REQ-041 Saturation: preload 0xFFFE, apply two discarding flushes -> flush_cnt=0xFFFF, remains 0xFFFF.
REQ-042 Async reset: drop rst_n between clock edges at occupancy=2 -> outputs reset before the next edge; flush_cnt=0; in_ready=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with a registered ready,
// a priority flush that squashes held/incoming work, and a saturating discard counter.
module pipe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 40,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [15:0]       flush_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [1:0]  state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    entry_t      in_ent;
    logic [15:0] cnt_q, cnt_d;
    logic        accept, release_w, discard;

    // State encoding doubles as the occupancy count; valids decode from it.
    assign occupancy = state_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_TWO);
    assign out_data  = main_q.data;
    assign out_ctrl  = out_valid ? main_q.ctrl : '0;
    assign flush_cnt = cnt_q;

    assign in_ent    = '{ctrl: in_ctrl, data: in_data};
    assign accept    = in_valid & in_ready;
    assign release_w = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_ent;
                end
            end
            ST_ONE: begin
                case ({accept, release_w})
                    2'b11: main_d = in_ent;
                    2'b10: begin
                        state_d = ST_TWO;
                        skid_d  = in_ent;
                    end
                    2'b01: begin
                        state_d     = ST_EMPTY;
                        main_d.ctrl = '0;
                    end
                    default: ;
                endcase
            end
            ST_TWO: begin
                if (release_w) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush overrides everything above; a same-cycle release still completes downstream.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_d.ctrl = '0;
            skid_d.ctrl = '0;
            main_d.data = CLEAR_DATA ? '0 : main_q.data;
            skid_d.data = CLEAR_DATA ? '0 : skid_q.data;
        end
    end

    // Something is lost only if a held entry survives past the release or input is swallowed.
    assign discard = flush & (accept | (state_q == ST_TWO) |
                              ((state_q == ST_ONE) & ~release_w));

    always_comb begin
        cnt_d = cnt_q;
        if (discard && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized + directed bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;
    logic [15:0]   flush_cnt;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two {ctrl,data} entries.
    typedef struct { logic [CW-1:0] ctrl; logic [DW-1:0] data; } ent_t;
    ent_t        q[$];
    logic [15:0] m_cnt = '0;
    bit          m_flushed = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_cnt = '0;
                m_flushed = 1'b0;
            end else begin
                bit acc, rel;
                int held;
                ent_t e;
                acc = in_valid && (q.size() < 2);
                rel = out_ready && (q.size() > 0);
                m_flushed = 1'b0;
                if (flush) begin
                    held = q.size() - (rel ? 1 : 0);
                    if ((held > 0 || acc) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    q.delete();
                    m_flushed = 1'b1;
                end else begin
                    if (rel) void'(q.pop_front());
                    if (acc) begin
                        e.ctrl = in_ctrl;
                        e.data = in_data;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    // Compare process: outputs are stable mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("occupancy", 64'(occupancy), 64'(q.size()));
                chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
                chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
                chk("flush_cnt", 64'(flush_cnt), 64'(m_cnt));
                if (q.size() > 0) begin
                    chk("out_data", 64'(out_data), 64'(q[0].data));
                    chk("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
                end else begin
                    chk("out_ctrl_idle", 64'(out_ctrl), 64'd0);
                    if (m_flushed) chk("out_data_flushed", 64'(out_data), 64'd0);
                end
            end
        end
    end

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return {d[7:0], d};
    endfunction

    task automatic step(input logic iv, input logic [DW-1:0] d, input logic orr, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = ctrl_of(d);
        out_ready = orr;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] r64;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; flush = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Streaming
        step(1'b1, 32'd1, 1'b1, 1'b0);
        chk("stream_first", 64'(out_data), 64'd1);
        for (int i = 2; i <= 6; i++) begin
            step(1'b1, DW'(i), 1'b1, 1'b0);
            chk("stream_data", 64'(out_data), 64'(i));
            chk("stream_occ", 64'(occupancy), 64'd1);
            chk("stream_rdy", 64'(in_ready), 64'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("stream_drain", 64'(occupancy), 64'd0);

        // Backpressure
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_rdy", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(out_data), 64'hA);
        chk("bp_ctrl", 64'(out_ctrl), 64'(ctrl_of(32'hA)));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("bp_second", 64'(out_data), 64'hB);
        chk("bp_occ1", 64'(occupancy), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("bp_empty", 64'(occupancy), 64'd0);

        // Flush while full
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ctrl", 64'(out_ctrl), 64'd0);
        chk("fl_data", 64'(out_data), 64'd0);
        chk("fl_cnt", 64'(flush_cnt), 64'd1);

        // Flush with simultaneous release and accept
        step(1'b1, 32'hC, 1'b1, 1'b0);
        chk("fra_head", 64'(out_data), 64'hC);
        step(1'b1, 32'hD, 1'b1, 1'b1);
        chk("fra_occ", 64'(occupancy), 64'd0);
        chk("fra_cnt", 64'(flush_cnt), 64'd2);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("fl_noop_cnt", 64'(flush_cnt), 64'd2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r64 = {$urandom(), $urandom()};
            in_valid  = ($urandom_range(3) != 0);
            in_data   = r64[DW-1:0];
            in_ctrl   = {r64[DW-1:DW-8], ~r64[DW-1:0]};
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(15) == 0);
            @(posedge clk); #1;
        end

        // Async reset mid-operation with two entries held
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h1A, 1'b0, 1'b0);
        step(1'b1, 32'h1B, 1'b0, 1'b0);
        chk("ar_pre_occ", 64'(occupancy), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_occ", 64'(occupancy), 64'd0);
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_data", 64'(out_data), 64'd0);
        chk("ar_ctrl", 64'(out_ctrl), 64'd0);
        chk("ar_cnt", 64'(flush_cnt), 64'd0);
        chk("ar_rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = ctrl_of(32'h55);
        out_ready = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_occ", 64'(occupancy), 64'd1);
        chk("post_rst_data", 64'(out_data), 64'h55);

        // Saturation: every flush cycle swallows an incoming accept
        for (int i = 0; i < 16'hFFFE; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
        chk("sat_pre", 64'(flush_cnt), 64'hFFFE);
        step(1'b1, 32'h1, 1'b0, 1'b1);
        step(1'b1, 32'h2, 1'b0, 1'b1);
        chk("sat_max", 64'(flush_cnt), 64'hFFFF);
        step(1'b1, 32'h3, 1'b0, 1'b1);
        chk("sat_hold", 64'(flush_cnt), 64'hFFFF);

        step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk); #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
